// File: rtl/conv_mem_responder_if.sv
// Signal bundle between a conv master port / host loader and conv_mem_responder.
interface conv_mem_responder_if #(
  parameter int CNT_W = 16
);
  logic             S_R_req;
  logic [31:0]      S_addr;
  logic [3:0]       S_W_req;
  logic [31:0]      S_W_data;
  logic [31:0]      S_R_data;
  logic             H_req;
  logic             H_we;
  logic [31:0]      H_addr;
  logic [31:0]      H_W_data;
  logic [31:0]      H_R_data;
  logic             H_ack;
  logic             err_clr;
  logic             addr_err;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;

  modport master (
    output S_R_req, S_addr, S_W_req, S_W_data, H_req, H_we, H_addr, H_W_data, err_clr,
    input  S_R_data, H_R_data, H_ack, addr_err, rd_cnt, wr_cnt
  );

  modport slave (
    input  S_R_req, S_addr, S_W_req, S_W_data, H_req, H_we, H_addr, H_W_data, err_clr,
    output S_R_data, H_R_data, H_ack, addr_err, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/conv_mem_responder.sv
// Word memory serving one conv master port with absolute priority; a host port
// loads/unloads words only in cycles where the master is idle.
module conv_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  conv_mem_responder_if.slave bus
);
  localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]      DEPTH_W   = 32'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [1:0]       ST_IDLE   = 2'd0;
  localparam logic [1:0]       ST_ACCESS = 2'd1;
  localparam logic [1:0]       ST_ACK    = 2'd2;

  logic [31:0]      mem_r [DEPTH];
  logic [1:0]       state_r;
  logic [31:0]      s_r_data_r;
  logic [31:0]      h_r_data_r;
  logic             h_ack_r;
  logic             addr_err_r;
  logic [CNT_W-1:0] rd_cnt_r;
  logic [CNT_W-1:0] wr_cnt_r;

  logic [29:0]      m_idx_s;
  logic [29:0]      h_idx_s;
  logic [AW-1:0]    m_ptr_s;
  logic [AW-1:0]    h_ptr_s;
  logic             m_rd_s;
  logic             m_wr_s;
  logic             m_active_s;
  logic             m_oob_s;
  logic             h_oob_s;
  logic             h_go_s;
  logic             err_set_s;
  logic             unused_addr_s;

  // Address decode, range checks and the host-may-proceed condition.
  always_comb begin
    m_idx_s       = bus.S_addr[31:2];
    h_idx_s       = bus.H_addr[31:2];
    m_ptr_s       = m_idx_s[AW-1:0];
    h_ptr_s       = h_idx_s[AW-1:0];
    m_rd_s        = bus.S_R_req;
    m_wr_s        = (bus.S_W_req != 4'b0000);
    m_active_s    = m_rd_s | m_wr_s;
    m_oob_s       = ({2'b00, m_idx_s} >= DEPTH_W);
    h_oob_s       = ({2'b00, h_idx_s} >= DEPTH_W);
    h_go_s        = (state_r == ST_ACCESS) && !m_active_s;
    err_set_s     = (m_active_s && m_oob_s) || (h_go_s && h_oob_s);
    unused_addr_s = ^{bus.S_addr[1:0], bus.H_addr[1:0]};
  end

  // Storage array: master byte-lane writes, host full-word writes; never cleared by reset.
  always_ff @(posedge clk) begin
    if (m_wr_s && !m_oob_s) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.S_W_req[k]) begin
          mem_r[m_ptr_s][8*k +: 8] <= bus.S_W_data[8*k +: 8];
        end
      end
    end else if (h_go_s && bus.H_we && !h_oob_s) begin
      mem_r[h_ptr_s] <= bus.H_W_data;
    end
  end

  // Master read data (pre-write word on a same-cycle write), activity counters, sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_r_data_r <= 32'h0000_0000;
      rd_cnt_r   <= {CNT_W{1'b0}};
      wr_cnt_r   <= {CNT_W{1'b0}};
      addr_err_r <= 1'b0;
    end else begin
      if (m_rd_s) begin
        s_r_data_r <= m_oob_s ? 32'h0000_0000 : mem_r[m_ptr_s];
      end
      if (m_rd_s && (rd_cnt_r != CNT_MAX)) begin
        rd_cnt_r <= rd_cnt_r + CNT_ONE;
      end
      if (m_wr_s && (wr_cnt_r != CNT_MAX)) begin
        wr_cnt_r <= wr_cnt_r + CNT_ONE;
      end
      if (err_set_s) begin
        addr_err_r <= 1'b1;
      end else if (bus.err_clr) begin
        addr_err_r <= 1'b0;
      end
    end
  end

  // Host sequencer: ACCESS waits out any master activity so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      h_ack_r    <= 1'b0;
      h_r_data_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          h_ack_r <= 1'b0;
          if (bus.H_req && !m_active_s) begin
            state_r <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (h_go_s) begin
            state_r <= ST_ACK;
            h_ack_r <= 1'b1;
            if (h_oob_s) begin
              h_r_data_r <= 32'h0000_0000;
            end else if (!bus.H_we) begin
              h_r_data_r <= mem_r[h_ptr_s];
            end
          end
        end
        ST_ACK: begin
          state_r <= ST_IDLE;
          h_ack_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          h_ack_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.S_R_data = s_r_data_r;
  assign bus.H_R_data = h_r_data_r;
  assign bus.H_ack    = h_ack_r;
  assign bus.addr_err = addr_err_r;
  assign bus.rd_cnt   = rd_cnt_r;
  assign bus.wr_cnt   = wr_cnt_r;
endmodule

// File: tb/tb_conv_mem_responder.sv
// Randomized scoreboard bench for conv_mem_responder against a word-array reference model.
module tb_conv_mem_responder;
  localparam int DEPTH = 1024;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CNT_W-1:0] rd;
    logic [CNT_W-1:0] wr;
    logic             err;
    logic             err_known;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  conv_mem_responder_if #(.CNT_W(CNT_W)) bus ();
  conv_mem_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] s_q [$];
  logic [31:0] h_q [$];
  st_t         st_q [$];
  logic [31:0] ref_mem [int unsigned];
  int          m_rd = 0;
  int          m_wr = 0;
  logic        m_err = 1'b0;
  logic [31:0] m_hrd = 32'h0;
  logic        host_oob_pend = 1'b0;
  logic        rd_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input int unsigned idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return 32'h0;
  endfunction

  task automatic push_status();
    st_t s;
    s.rd        = CNT_W'(m_rd);
    s.wr        = CNT_W'(m_wr);
    s.err       = m_err;
    s.err_known = !host_oob_pend;
    st_q.push_back(s);
  endtask

  task automatic model_reset();
    m_rd  = 0;
    m_wr  = 0;
    m_err = 1'b0;
    m_hrd = 32'h0;
  endtask

  // Reference behaviour of one clock edge for the master port, from the current inputs.
  task automatic model_edge();
    int unsigned idx;
    logic        oob;
    logic        act;
    logic [31:0] w;
    if (rst !== 1'b1) begin
      model_reset();
    end else begin
      idx = bus.S_addr >> 2;
      oob = (idx >= DEPTH);
      act = bus.S_R_req || (bus.S_W_req != 4'b0);
      if (bus.S_R_req) begin
        s_q.push_back(oob ? 32'h0 : rd_word(idx));
        if (m_rd < CMAX) m_rd++;
      end
      if (bus.S_W_req != 4'b0) begin
        if (!oob) begin
          w = rd_word(idx);
          for (int k = 0; k < 4; k++) begin
            if (bus.S_W_req[k]) w[8*k +: 8] = bus.S_W_data[8*k +: 8];
          end
          ref_mem[idx] = w;
        end
        if (m_wr < CMAX) m_wr++;
      end
      if (act && oob) m_err = 1'b1;
      else if (bus.err_clr) m_err = 1'b0;
    end
    push_status();
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.S_R_req  = 1'b0;
    bus.S_W_req  = 4'b0;
    bus.S_addr   = 32'h0;
    bus.S_W_data = 32'h0;
    bus.err_clr  = 1'b0;
    bus.H_req    = 1'b0;
  endtask

  task automatic m_op(input logic rd, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
    bus.S_R_req  = rd;
    bus.S_W_req  = we;
    bus.S_addr   = addr;
    bus.S_W_data = data;
    step();
    idle_inputs();
  endtask

  // Host access with the master reading word 0 for `busy` cycles; ack due busy+2 cycles after H_req.
  task automatic host_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int busy);
    int unsigned idx;
    logic        oob;
    int          lat;
    logic        got;
    idx = addr >> 2;
    oob = (idx >= DEPTH);
    lat = 0;
    got = 1'b0;
    idle_inputs();
    if (oob) m_hrd = 32'h0;
    else if (!we) m_hrd = rd_word(idx);
    h_q.push_back(m_hrd);
    host_oob_pend = oob;
    bus.H_req    = 1'b1;
    bus.H_we     = we;
    bus.H_addr   = addr;
    bus.H_W_data = wdata;
    while (!got && lat < 20) begin
      bus.S_R_req = (lat < busy);
      bus.S_addr  = 32'h0;
      step();
      lat++;
      got = (bus.H_ack === 1'b1);
    end
    idle_inputs();
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL host_ack_timeout: got no H_ack in %0d cycles, expected one after %0d", lat, busy + 2);
    end else begin
      chk("host_latency", 32'(lat), 32'(busy + 2));
      if (we && !oob) ref_mem[idx] = wdata;
      if (oob) m_err = 1'b1;
    end
    host_oob_pend = 1'b0;
    step();
  endtask

  // Note which edges carried a master read, so the following half-cycle checks its data.
  always @(posedge clk) rd_seen <= rst && bus.S_R_req;

  // Scoreboard monitor: pops an expectation whenever the DUT presents an output.
  always @(negedge clk) begin
    st_t s;
    if (rd_seen) begin
      if (s_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL s_r_data: read data with no expectation queued, got 0x%08h", bus.S_R_data);
      end else begin
        chk("s_r_data", bus.S_R_data, s_q.pop_front());
      end
    end
    if (bus.H_ack === 1'b1) begin
      if (h_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL h_ack: got unexpected pulse, expected none");
      end else begin
        chk("h_r_data", bus.H_R_data, h_q.pop_front());
      end
    end
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      chk("rd_cnt", 32'(bus.rd_cnt), 32'(s.rd));
      chk("wr_cnt", 32'(bus.wr_cnt), 32'(s.wr));
      if (s.err_known) chk("addr_err", 32'(bus.addr_err), 32'(s.err));
    end
  end

  initial begin
    idle_inputs();
    bus.H_we     = 1'b0;
    bus.H_addr   = 32'h0;
    bus.H_W_data = 32'h0;
    rst = 1'b0;
    repeat (3) step();
    chk("rst_s_r_data", bus.S_R_data, 32'h0);
    chk("rst_h_r_data", bus.H_R_data, 32'h0);
    chk("rst_h_ack", 32'(bus.H_ack), 32'h0);
    rst = 1'b1;
    step();

    for (int w = 0; w < 32; w++) host_op(1'b1, 32'(w * 4), $urandom, 0);

    m_op(1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF);
    m_op(1'b1, 4'h0, 32'h10, 32'h0);

    host_op(1'b1, 32'h20, 32'h1122_3344, 0);
    m_op(1'b0, 4'b0101, 32'h20, 32'hAABB_CCDD);
    m_op(1'b1, 4'h0, 32'h20, 32'h0);

    host_op(1'b1, 32'h30, 32'h7, 0);
    m_op(1'b1, 4'hF, 32'h30, 32'h5);
    m_op(1'b1, 4'h0, 32'h30, 32'h0);

    m_op(1'b1, 4'h0, 32'(DEPTH * 4), 32'h0);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    host_op(1'b0, 32'(DEPTH * 4 + 8), 32'h0, 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;

    host_op(1'b0, 32'h20, 32'h0, 3);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        host_op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 31) * 4), $urandom, $urandom_range(0, 3));
      end else begin
        bus.S_R_req  = 1'($urandom_range(0, 1));
        bus.S_W_req  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0;
        bus.S_addr   = ($urandom_range(0, 15) == 0) ? 32'((DEPTH + $urandom_range(0, 100)) * 4)
                                                    : 32'($urandom_range(0, 31) * 4);
        bus.S_addr   = bus.S_addr | 32'($urandom_range(0, 3));
        bus.S_W_data = $urandom;
        bus.err_clr  = ($urandom_range(0, 7) == 0);
        step();
      end
    end
    idle_inputs();
    step();

    bus.H_req  = 1'b1;
    bus.H_we   = 1'b0;
    bus.H_addr = 32'h20;
    step();
    rst = 1'b0;
    bus.H_req = 1'b0;
    model_reset();
    st_q.delete();
    push_status();
    #1;
    chk("arst_s_r_data", bus.S_R_data, 32'h0);
    chk("arst_h_r_data", bus.H_R_data, 32'h0);
    chk("arst_h_ack", 32'(bus.H_ack), 32'h0);
    chk("arst_addr_err", 32'(bus.addr_err), 32'h0);
    chk("arst_rd_cnt", 32'(bus.rd_cnt), 32'h0);
    chk("arst_wr_cnt", 32'(bus.wr_cnt), 32'h0);
    repeat (3) step();
    rst = 1'b1;
    step();
    host_op(1'b0, 32'h20, 32'h0, 0);

    repeat (3) step();
    chk("s_q_drained", 32'(s_q.size()), 32'h0);
    chk("h_q_drained", 32'(h_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
